// File: rtl/obstacle_gen_if.sv
// obstacle_gen_if: game-control inputs and obstacle descriptor outputs of obstacle_gen.
interface obstacle_gen_if;
    logic        tick;
    logic        run;
    logic [3:0]  speed;
    logic        bird_en;
    logic [14:0] obstacle;
    logic        spawn;
    logic        passed;
    modport master (output tick, run, speed, bird_en, input obstacle, spawn, passed);
    modport slave  (input tick, run, speed, bird_en, output obstacle, spawn, passed);
endinterface

// File: rtl/obstacle_gen.sv
// obstacle_gen: random-gap obstacle spawner/scroller producing {en, type, col}.
// Define OBSTGEN_BIRD_EN to let bird_en enable bird types; otherwise only cacti.
module obstacle_gen #(
    parameter int          SCREEN_W = 640,
    parameter int          MIN_GAP  = 40,
    parameter int          GAP_BITS = 6,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input logic           clk,
    input logic           rst,
    obstacle_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GAP, MOVE} state_t;
    localparam logic [15:0] GAP_MASK = 16'((1 << GAP_BITS) - 1);
    localparam logic [3:0] TYPE_BIRD [16] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd5, 4'd5, 4'd6,
                                              4'd6, 4'd7, 4'd9, 4'd9, 4'd10, 4'd10, 4'd11, 4'd11};
    localparam logic [3:0] TYPE_CACT [16] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd5, 4'd5, 4'd6,
                                              4'd6, 4'd7, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7};
    state_t      state, state_n;
    logic [15:0] lfsr, lfsr_n, gap, gap_n, gap_load;
    logic [14:0] obst, obst_n;
    logic        spawn, spawn_n, passed, passed_n, q, birds;
    logic [3:0]  sp_type;
    logic [9:0]  col, width, sp_col;
`ifdef OBSTGEN_BIRD_EN
    assign birds = bus.bird_en;
`else
    logic unused_bird_en;
    assign unused_bird_en = bus.bird_en;
    assign birds = 1'b0;
`endif
    assign q        = bus.tick & bus.run;
    assign col      = obst[9:0];
    assign gap_load = 16'(MIN_GAP) + ((lfsr >> 4) & GAP_MASK);
    assign sp_type  = birds ? TYPE_BIRD[lfsr[3:0]] : TYPE_CACT[lfsr[3:0]];
    assign width    = sp_type == 4'd1 ? 10'd17 : sp_type == 4'd2 ? 10'd34 :
                      sp_type == 4'd3 ? 10'd51 : sp_type == 4'd5 ? 10'd25 :
                      sp_type == 4'd6 ? 10'd50 : sp_type == 4'd7 ? 10'd75 : 10'd46;
    assign sp_col   = 10'(SCREEN_W) + width;
    assign lfsr_n   = q ? {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]} : lfsr;
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            lfsr   <= SEED;
            gap    <= '0;
            obst   <= '0;
            spawn  <= 1'b0;
            passed <= 1'b0;
        end else begin
            state  <= state_n;
            lfsr   <= lfsr_n;
            gap    <= gap_n;
            obst   <= obst_n;
            spawn  <= spawn_n;
            passed <= passed_n;
        end
    end
    // retire test precedes subtraction, so col never wraps
    always_comb begin
        state_n  = state;
        gap_n    = gap;
        obst_n   = obst;
        spawn_n  = 1'b0;
        passed_n = 1'b0;
        if (q) begin
            case (state)
                IDLE: begin
                    gap_n   = gap_load;
                    state_n = GAP;
                end
                GAP: begin
                    if (gap != '0) begin
                        gap_n = gap - 16'd1;
                    end else begin
                        obst_n  = {1'b1, sp_type, sp_col};
                        spawn_n = 1'b1;
                        state_n = MOVE;
                    end
                end
                MOVE: begin
                    if (col > 10'(bus.speed)) begin
                        obst_n = {obst[14:10], col - 10'(bus.speed)};
                    end else begin
                        obst_n   = '0;
                        passed_n = 1'b1;
                        gap_n    = gap_load;
                        state_n  = GAP;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
    assign bus.obstacle = obst;
    assign bus.spawn    = spawn;
    assign bus.passed   = passed;
endmodule
